// File: rtl/tlut_result_serializer.sv
// tlut_result_serializer
//   Captures one DIM-wide result vector from the TLUT multiplier array and
//   streams it out one element per cycle, element 0 first. A new vector can
//   be captured on the same cycle the last element of the current one is
//   accepted, so back-to-back vectors drain with no bubble.
//
//   Optional: define TLUT_SER_VEC_CNT_EN to add a 16-bit completed-vector
//   counter on port vec_cnt.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   in_valid/ready  result vector handshake from the array
//   in_data         DIM x WIDTH result vector
//   out_valid/ready element handshake to writeback
//   out_data        current element
//   out_idx         index of current element in its vector
//   out_last        current element is element DIM-1
//   vec_cnt         completed vectors (TLUT_SER_VEC_CNT_EN only)

`ifndef DIM_A
`define DIM_A 4
`endif

module tlut_result_serializer #(
  parameter int DIM   = `DIM_A,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(DIM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIM-1:0][WIDTH-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDXW-1:0]            out_idx,
  output logic                       out_last
`ifdef TLUT_SER_VEC_CNT_EN
  ,
  output logic [15:0]                vec_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIM - 1);

  state_t                      state_q, state_d;
  logic [DIM-1:0][WIDTH-1:0]   cap_q, cap_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        in_xfer, out_xfer;

  // Outputs come straight from registered state; only in_ready looks at
  // out_ready, and only on the last element (the no-bubble handoff).
  assign out_valid = (state_q == DRAIN);
  assign out_data  = cap_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          cap_d   = in_data;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (!out_last) begin
            // Increment only below DIM-1, so idx wraps explicitly even
            // when DIM is not a power of two.
            idx_d = idx_q + IDXW'(1);
          end else if (in_xfer) begin
            cap_d = in_data;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

`ifdef TLUT_SER_VEC_CNT_EN
  logic [15:0] vec_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   vec_cnt_q <= '0;
    else if (out_xfer && out_last) vec_cnt_q <= vec_cnt_q + 16'd1;
  end

  assign vec_cnt = vec_cnt_q;
`endif

endmodule

// File: tb/tb_tlut_result_serializer.sv
module tb_tlut_result_serializer;

  localparam int DIM   = 4;
  localparam int WIDTH = 16;
  localparam int IDXW  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDXW-1:0]  idx;
    logic             last;
  } beat_t;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [DIM-1:0][WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [IDXW-1:0]           out_idx;
  logic                      out_last;
`ifdef TLUT_SER_VEC_CNT_EN
  logic [15:0]               vec_cnt;
`endif

  tlut_result_serializer #(.DIM(DIM), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef TLUT_SER_VEC_CNT_EN
    ,
    .vec_cnt   (vec_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  beat_t sb[$];

  // beat tracking for the no-bubble check
  int    nbeats;
  int    first_beat;
  int    last_beat;

  // stall stability tracking
  logic             stall_prev;
  logic [WIDTH-1:0] prev_data;
  logic [IDXW-1:0]  prev_idx;
  logic             prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops expected beats on output transfers, pushes expected beats
  // on input transfers, and checks holds across stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_vld",  {31'd0, out_valid}, 32'd1);
        chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        chk("stall_idx",  {30'd0, out_idx},  {30'd0, prev_idx});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("extra_beat", {16'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("in_rdy_drain", {31'd0, in_ready}, {31'd0, sb[0].last & out_ready});
          if (out_ready) begin
            beat_t e;
            e = sb.pop_front();
            chk("data", {16'd0, out_data}, {16'd0, e.data});
            chk("idx",  {30'd0, out_idx},  {30'd0, e.idx});
            chk("last", {31'd0, out_last}, {31'd0, e.last});
            if (nbeats == 0) first_beat = cyc;
            last_beat = cyc;
            nbeats++;
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < DIM; k++) begin
          beat_t b;
          b.data = in_data[k];
          b.idx  = IDXW'(k);
          b.last = (k == DIM - 1);
          sb.push_back(b);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
    end
  end

  // Drive a vector and hold in_valid until it is captured. Returns at
  // posedge+1 after the capturing edge.
  task automatic send_vec(input logic [DIM-1:0][WIDTH-1:0] v, input bit keep);
    bit ok;
    ok       = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_to", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_to", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  logic [DIM-1:0][WIDTH-1:0] va, vb;
  logic [6:0]                pat;

  initial begin
    nbeats     = 0;
    first_beat = 0;
    last_beat  = 0;
    stall_prev = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    #12;
    // reset state
    chk("rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data},  32'd0);
    chk("rst_idx",  {30'd0, out_idx},   32'd0);
    chk("rst_last", {31'd0, out_last},  32'd0);
    chk("rst_rdy",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic drain
    out_ready = 1'b1;
    va = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    send_vec(va, 1'b0);
    chk("lat_vld",  {31'd0, out_valid}, 32'd1);
    chk("lat_data", {16'd0, out_data},  32'h0001);
    wait_idle();
    chk("basic_vld", {31'd0, out_valid}, 32'd0);
    chk("basic_rdy", {31'd0, in_ready},  32'd1);

    // back-to-back, in_valid held across both vectors
    va = {16'd4, 16'd3, 16'd2, 16'd1};
    vb = {16'd8, 16'd7, 16'd6, 16'd5};
    nbeats = 0;
    send_vec(va, 1'b1);
    send_vec(vb, 1'b0);
    wait_idle();
    chk("b2b_beats", nbeats, 32'd8);
    chk("b2b_span",  last_beat - first_beat, 32'd7);

    // backpressure: out_ready 1,0,0,1,0,1,1 (LSB first)
    out_ready = 1'b1;
    pat = 7'b1101001;
    va  = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    nbeats = 0;
    send_vec(va, 1'b0);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_beats", nbeats, 32'd4);

    // input ignored while draining non-last beats
    va = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    nbeats = 0;
    send_vec(va, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {DIM{16'($urandom_range(16'h1000, 16'hFFFF))}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    chk("ign_beats", nbeats, 32'd4);

    // reset mid-vector after 2 of 4 elements
    va = {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1};
    send_vec(va, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("mid_idx_pre", {30'd0, out_idx}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld",  {31'd0, out_valid}, 32'd0);
    chk("mrst_idx",  {30'd0, out_idx},   32'd0);
    chk("mrst_data", {16'd0, out_data},  32'd0);
    chk("mrst_last", {31'd0, out_last},  32'd0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rdy", {31'd0, in_ready},  32'd1);
      chk("post_vld", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;

`ifdef TLUT_SER_VEC_CNT_EN
    chk("cnt_rst", {16'd0, vec_cnt}, 32'd0);
    for (int v = 0; v < 3; v++) begin
      va = {16'(v * 4 + 4), 16'(v * 4 + 3), 16'(v * 4 + 2), 16'(v * 4 + 1)};
      send_vec(va, 1'b0);
    end
    wait_idle();
    chk("cnt_3", {16'd0, vec_cnt}, 32'd3);
    @(negedge clk);
    force dut.vec_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.vec_cnt_q;
    chk("cnt_pre", {16'd0, vec_cnt}, 32'h0000_FFFF);
    va = {16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01};
    send_vec(va, 1'b0);
    wait_idle();
    chk("cnt_wrap", {16'd0, vec_cnt}, 32'd0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/tlut_result_serializer.md
Name: tlut_result_serializer

Overview:
- Other end of the array input path: the input register fans a DIM-wide vector into the TLUT multiplier array; this block collects the array's DIM-wide result vector and streams it out one element per cycle.
- Sits between the array output and the downstream writeback/accumulator interface.
- Uses a valid/ready handshake on both sides. Holds one vector in a capture register and drains it element by element.
- Accepts back-to-back vectors with no bubble between them.

Parameters:
- DIM, default `DIM_A: elements per result vector; must be ≥2.
- WIDTH, default 16: bits per result element.
- IDXW, default $clog2(DIM): width of the element index.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- in_valid, input, 1: array result vector present.
- in_ready, output, 1: block can capture in_data this cycle.
- in_data, input, [DIM-1:0][WIDTH-1:0]: result vector; element 0 is sent first.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts the current element.
- out_data, output, WIDTH: current element.
- out_idx, output, IDXW: index of the current element within its vector.
- out_last, output, 1: current element is element DIM-1.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - Capture register cleared to 0; idx=0.
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1 (combinational from IDLE).
- Reset asserted mid-vector: the partially sent vector is discarded and nothing is replayed after release.
- States:
  - IDLE: register empty.
  - DRAIN: register holds a vector; idx points to the next element to send.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Combinational outputs:
  - out_valid = (state==DRAIN).
  - out_data = reg[idx].
  - out_idx = idx.
  - out_last = (state==DRAIN) & (idx==DIM-1).
  - in_ready = (state==IDLE) | (out_last & out_ready).
- Transitions:
  - IDLE + input transfer: capture in_data, idx←0, go to DRAIN. First element is visible the next cycle, so input-to-first-output latency is 1 cycle.
  - DRAIN + output transfer + !out_last: idx←idx+1.
  - DRAIN + output transfer + out_last + input transfer: capture the new vector, idx←0, stay in DRAIN. This is the no-bubble case.
  - DRAIN + output transfer + out_last + no input transfer: go to IDLE, idx←0.
  - DRAIN + !out_ready: hold. out_data, out_idx and out_last stay stable while stalled.
- Flow rules:
  - A full vector takes exactly DIM output transfers.
  - Sustained throughput is 1 element/cycle when out_ready is held at 1.
  - in_data is sampled only on an input transfer. Changes in in_data at any other time have no effect.
  - idx never exceeds DIM-1.
  - When DIM is not a power of two, idx wraps explicitly to 0 after DIM-1.
- Protocol:
  - out_valid does not depend combinationally on out_ready.
  - in_ready depends combinationally on out_ready only in the last-element case.
- No data is dropped or duplicated under any out_ready pattern.

Optional Feature:
- Macro: TLUT_SER_VEC_CNT_EN.
- Defined:
  - Adds output port vec_cnt, 16 bits.
  - Counts completed vectors, i.e. output transfers with out_last=1.
  - Reset to 0; wraps 0xFFFF→0x0000.
  - Updates one cycle after the last element is accepted.
- Undefined:
  - No port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Basic drain:
  - Setup: DIM=4, WIDTH=16, out_ready=1; one vector {0x0004,0x0003,0x0002,0x0001} (element 0=0x0001).
  - Response: out_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles starting 1 cycle after the input transfer.
  - out_idx 0..3; out_last only with 0x0004; then out_valid=0 and in_ready=1.
- Back-to-back:
  - Stimulus: two vectors A={1,2,3,4} and B={5,6,7,8} with in_valid held and out_ready=1.
  - Response: 8 consecutive output beats 1..8 with no idle cycle; in_ready=1 only in IDLE and on A's last beat.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,0,1,1 during vector {0xA,0xB,0xC,0xD}.
  - Response: each element is held stable while stalled; sequence is A,B,C,D exactly once; in_ready=0 until the D transfer.
- Input ignored while draining:
  - Stimulus: change in_data every cycle with in_valid=1 during DRAIN, on non-last beats.
  - Response: output matches the originally captured vector; no capture occurs.
- Reset mid-vector:
  - Stimulus: assert rst_n=0 asynchronously after 2 of 4 elements are sent.
  - Response: out_valid=0, out_idx=0, out_data=0 immediately; after release the block is in IDLE with in_ready=1 and no residual elements.
- Counter (TLUT_SER_VEC_CNT_EN):
  - Stimulus: 3 full vectors.
  - Response: vec_cnt=3; preloaded via force to 0xFFFF plus one vector gives vec_cnt=0x0000.
